// File: rtl/weight_bram_sequencer.sv
// Sequencer for one ANN weight BRAM: loads a weight set from a host stream and
// streams it back to the neuron MAC through a 2-entry skid FIFO.

module weight_bram_sequencer #(
   parameter int DEPTH = 28,
   parameter int AW    = 5,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_load,
   input  logic          start_stream,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_valid,
   output logic          ld_ready,
   output logic [AW-1:0] bram_addr,
   output logic [DW-1:0] bram_di,
   output logic          bram_en,
   output logic          bram_we,
   input  logic [DW-1:0] bram_do,
   output logic [DW-1:0] w_data,
   output logic          w_valid,
   input  logic          w_ready,
   output logic          w_last,
   output logic          busy,
   output logic          done
);

   // state  | meaning
   // IDLE   | waiting for start_load / start_stream
   // LOAD   | writing host words into addresses 0..DEPTH-1
   // STREAM | reading addresses 0..DEPTH-1 into the skid FIFO
   // FIN    | one-cycle done pulse, FIFO flushed, back to IDLE

   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_STREAM = 2'd2,
      S_FIN    = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    occ;
   logic [DW-1:0] e0_data, e1_data;
   logic          e0_last, e1_last;

   logic wr_hs;
   logic rd_issue;
   logic pop;
   logic push_last;

   assign w_valid = (occ != 2'd0);
   assign w_data  = e0_data;
   assign w_last  = e0_last & w_valid;
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_FIN);

   assign pop       = w_valid & w_ready;
   assign wr_hs     = (state == S_LOAD) & ld_valid;
   // A read may be issued whenever the FIFO will have room at the next edge,
   // counting the slot freed by a pop in this same cycle.
   assign rd_issue  = (state == S_STREAM) && (cnt < CNT_END) && ((occ < 2'd2) || pop);
   assign push_last = (cnt == CNT_LAST);

   always_comb begin
      ld_ready  = 1'b0;
      bram_en   = 1'b0;
      bram_we   = 1'b0;
      bram_addr = '0;
      bram_di   = '0;
      if (state == S_LOAD) begin
         ld_ready = 1'b1;
      end
      if (wr_hs) begin
         bram_en   = 1'b1;
         bram_we   = 1'b1;
         bram_addr = cnt[AW-1:0];
         bram_di   = ld_data;
      end else if (rd_issue) begin
         bram_en   = 1'b1;
         bram_addr = cnt[AW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (start_load) begin
                  state <= S_LOAD;
               end else if (start_stream) begin
                  state <= S_STREAM;
               end
            end
            S_LOAD: begin
               if (wr_hs) begin
                  if (cnt != CNT_END) begin
                     cnt <= cnt + CW'(1);
                  end
                  if (cnt == CNT_LAST) begin
                     state <= S_FIN;
                  end
               end
            end
            S_STREAM: begin
               if (rd_issue) begin
                  cnt <= cnt + CW'(1);
               end
               if (pop && e0_last) begin
                  state <= S_FIN;
               end
            end
            S_FIN: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Read data lands in the FIFO at the edge closing the issue cycle; the
   // head entry only moves on a pop so w_data is stable until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ     <= 2'd0;
         e0_data <= '0;
         e1_data <= '0;
         e0_last <= 1'b0;
         e1_last <= 1'b0;
      end else if (state != S_STREAM) begin
         occ     <= 2'd0;
         e0_last <= 1'b0;
         e1_last <= 1'b0;
      end else begin
         case ({rd_issue, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  e0_data <= bram_do;
                  e0_last <= push_last;
               end else begin
                  e1_data <= bram_do;
                  e1_last <= push_last;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               e0_data <= e1_data;
               e0_last <= e1_last;
               e1_last <= 1'b0;
               occ     <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  e0_data <= bram_do;
                  e0_last <= push_last;
               end else begin
                  e0_data <= e1_data;
                  e0_last <= e1_last;
                  e1_data <= bram_do;
                  e1_last <= push_last;
               end
            end
            default: begin
               occ <= occ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Bench for weight_bram_sequencer: behavioural BRAM, word-level scoreboard of
// loaded and streamed weights, table of load/stream scenarios plus reset cases.

module tb_weight_bram_sequencer;
   localparam int DEPTH = 28;
   localparam int AW    = 5;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start_load = 1'b0, start_stream = 1'b0;
   logic [DW-1:0] ld_data = '0;
   logic          ld_valid = 1'b0;
   logic          w_ready = 1'b0;
   logic [DW-1:0] bram_do = '0;
   logic          ld_ready, bram_en, bram_we, w_valid, w_last, busy, done;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_di, w_data;

   always #5 clk = ~clk;

   weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_stream(start_stream),
      .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .bram_addr(bram_addr), .bram_di(bram_di), .bram_en(bram_en), .bram_we(bram_we),
      .bram_do(bram_do), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
      .w_last(w_last), .busy(busy), .done(done)
   );

   // BRAM: samples EN/WE/ADDR at negedge, read data valid at the next posedge
   logic [DW-1:0] mem [2**AW];
   always @(negedge clk) begin
      if (bram_en) begin
         if (bram_we) mem[bram_addr] <= bram_di;
         else         bram_do <= mem[bram_addr];
      end
   end

   typedef struct {
      int          ld_mode;
      bit          rnd;
      logic [15:0] base;
      int          rd_mode;
      bit          conflict;
      int          exp_words;
      int          exp_done;
   } vec_t;

   vec_t          tbl [5];
   logic [DW-1:0] ref_mem [DEPTH];
   int total = 0, bad = 0, cyc = 0;
   int n_rd = 0, n_pop = 0, n_done = 0, max_ahead = 0, unstable = 0, we_stray = 0;
   int last_done_cyc = 0;
   bit load_window = 1'b0, hold_pending = 1'b0;
   logic [DW-1:0] hold_data = '0;
   logic [AW-1:0] wr_addr_q[$], rd_addr_q[$];
   logic [DW-1:0] wr_data_q[$], pop_data_q[$];
   bit            pop_last_q[$];
   int            wr_cyc_q[$], pop_cyc_q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bram_en && bram_we) begin
            wr_addr_q.push_back(bram_addr);
            wr_data_q.push_back(bram_di);
            wr_cyc_q.push_back(cyc);
            if (!load_window) we_stray++;
         end
         if (bram_en && !bram_we) begin
            rd_addr_q.push_back(bram_addr);
            n_rd++;
         end
         if (w_valid && w_ready) begin
            pop_data_q.push_back(w_data);
            pop_last_q.push_back(w_last);
            pop_cyc_q.push_back(cyc);
            n_pop++;
         end
         if (n_rd - n_pop > max_ahead) max_ahead = n_rd - n_pop;
         if (done) begin
            n_done++;
            last_done_cyc = cyc;
         end
         if (hold_pending && (!w_valid || w_data !== hold_data)) unstable++;
         hold_pending = w_valid && !w_ready;
         hold_data    = w_data;
      end else begin
         hold_pending = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic valid_for(int m, int k);
      case (m)
         0:       return 1'b1;
         1:       return (k % 2) == 0;
         default: return ($urandom_range(0, 2) != 0);
      endcase
   endfunction

   function automatic logic ready_for(int m, int k);
      case (m)
         0:       return 1'b1;
         1:       return !(k >= 5 && k <= 14);
         2:       return ($urandom_range(0, 2) != 0);
         default: return ($urandom_range(0, 3) == 0);
      endcase
   endfunction

   task automatic run_load(input vec_t v, input string tag);
      int idx, k, c0, dn0, not_ready, errs;
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      dn0 = n_done; not_ready = 0; errs = 0;
      load_window = 1'b1;
      @(posedge clk); #1;
      start_load = 1'b1; start_stream = v.conflict; c0 = cyc;
      @(posedge clk); #1;
      start_load = 1'b0; start_stream = 1'b0;
      idx = 0; k = 0;
      while (idx < DEPTH && k < 300) begin
         ld_valid     = valid_for(v.ld_mode, k);
         ld_data      = v.rnd ? DW'($urandom) : DW'(v.base + 16'(idx));
         start_stream = v.conflict && (k == 10);
         @(negedge clk);
         if (!ld_ready) not_ready++;
         if (ld_valid && ld_ready) begin
            ref_mem[idx] = ld_data;
            idx++;
         end
         @(posedge clk); #1;
         k++;
      end
      ld_valid = 1'b0; start_stream = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      load_window = 1'b0;
      chk({tag, " load words accepted"}, idx, v.exp_words);
      chk({tag, " ld_ready dropped in LOAD"}, not_ready, 0);
      chk({tag, " bram writes"}, wr_addr_q.size(), v.exp_words);
      for (int i = 0; i < wr_addr_q.size() && i < DEPTH; i++)
         if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== ref_mem[i]) errs++;
      chk({tag, " write addr/data errors"}, errs, 0);
      chk({tag, " done pulses"}, n_done - dn0, v.exp_done);
      chk({tag, " busy after load"}, busy, 0);
      if (v.ld_mode == 0 && wr_cyc_q.size() == DEPTH) begin
         chk({tag, " first write cycle"}, wr_cyc_q[0] - c0, 1);
         chk({tag, " last write cycle"}, wr_cyc_q[DEPTH-1] - c0, DEPTH);
         chk({tag, " done cycle"}, last_done_cyc - c0, DEPTH + 1);
      end
   endtask

   task automatic run_stream(input int rd_mode, input string tag);
      int k, c0, dn0, errs, lasts, ld_seen;
      rd_addr_q.delete(); pop_data_q.delete(); pop_last_q.delete(); pop_cyc_q.delete();
      n_rd = 0; n_pop = 0; max_ahead = 0; unstable = 0;
      dn0 = n_done; errs = 0; lasts = 0; ld_seen = 0;
      @(posedge clk); #1;
      start_stream = 1'b1; c0 = cyc; w_ready = ready_for(rd_mode, 0);
      @(posedge clk); #1;
      start_stream = 1'b0;
      k = 1;
      while (n_done == dn0 && k < 400) begin
         w_ready    = ready_for(rd_mode, k);
         start_load = (k == 8);
         @(negedge clk);
         if (ld_ready) ld_seen++;
         @(posedge clk); #1;
         k++;
      end
      start_load = 1'b0; w_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({tag, " stream finished in time"}, k < 400, 1);
      chk({tag, " words popped"}, pop_data_q.size(), DEPTH);
      for (int i = 0; i < pop_data_q.size() && i < DEPTH; i++) begin
         if (pop_data_q[i] !== ref_mem[i]) errs++;
         if (pop_last_q[i]) lasts++;
      end
      chk({tag, " stream data errors"}, errs, 0);
      chk({tag, " w_last count"}, lasts, 1);
      if (pop_last_q.size() == DEPTH) chk({tag, " w_last on final word"}, pop_last_q[DEPTH-1], 1);
      errs = 0;
      for (int i = 0; i < rd_addr_q.size(); i++)
         if (rd_addr_q[i] !== AW'(i)) errs++;
      chk({tag, " read address order"}, errs, 0);
      chk({tag, " reads issued"}, rd_addr_q.size(), DEPTH);
      chk({tag, " reads ahead over 2"}, max_ahead > 2, 0);
      chk({tag, " w_data unstable under stall"}, unstable, 0);
      chk({tag, " start_load during stream took effect"}, ld_seen, 0);
      chk({tag, " done pulses"}, n_done - dn0, 1);
      chk({tag, " busy after stream"}, busy, 0);
      if (rd_mode == 0 && pop_cyc_q.size() == DEPTH) begin
         chk({tag, " first w_valid latency"}, pop_cyc_q[0] - c0, 2);
         chk({tag, " last pop cycle"}, pop_cyc_q[DEPTH-1] - c0, DEPTH + 1);
         chk({tag, " done after last pop"}, last_done_cyc - pop_cyc_q[DEPTH-1], 1);
      end
   endtask

   function automatic logic [63:0] outs();
      return {ld_ready, bram_en, bram_we, bram_addr, bram_di, w_valid, w_last, busy, done};
   endfunction

   initial begin
      int seen;
      tbl[0] = '{0, 1'b0, 16'h0100, 0, 1'b0, DEPTH, 1};
      tbl[1] = '{1, 1'b0, 16'h0100, 1, 1'b0, DEPTH, 1};
      tbl[2] = '{2, 1'b1, 16'h0000, 2, 1'b0, DEPTH, 1};
      tbl[3] = '{0, 1'b1, 16'h0000, 3, 1'b0, DEPTH, 1};
      tbl[4] = '{0, 1'b0, 16'h0200, 0, 1'b1, DEPTH, 1};

      #2 rst_n = 1'b0;
      #1 chk("reset outputs", outs(), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // host data offered while idle must be ignored
      ld_valid = 1'b1; ld_data = 16'hdead; seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (ld_ready || bram_en) seen++;
      end
      @(posedge clk); #1 ld_valid = 1'b0;
      chk("idle ld_valid accepted", seen, 0);

      for (int r = 0; r < 5; r++) begin
         run_load(tbl[r], $sformatf("row%0d", r));
         run_stream(tbl[r].rd_mode, $sformatf("row%0d", r));
      end

      // reset in the middle of a stream, then restart from address 0
      @(posedge clk); #1;
      start_stream = 1'b1; w_ready = 1'b1;
      @(posedge clk); #1;
      start_stream = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("mid-stream reset outputs", outs(), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      w_ready = 1'b0;
      run_stream(0, "after reset");

      chk("bram_we outside LOAD", we_stray, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
